// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard scan-code receiver: synchronises the bus, samples it on a
// divided tick, frames and checks 11-bit characters, folds E0/F0 prefixes
// into key events and queues them in a small FIFO for the consumer.
module ps2_scan_receiver #(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    output logic                          EVT_VALID,
    input  logic                          EVT_READY,
    output logic [7:0]                    EVT_CODE,
    output logic                          EVT_BREAK,
    output logic                          EVT_EXT,
    output logic                          FRAME_ERR,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } evt_t;

    // ------------------------------------------------------------------
    // Synchronisers, sampling divider and frame assembly
    // ------------------------------------------------------------------
    logic             ps2_clk_s1_q, ps2_clk_s2_q;
    logic             ps2_dat_s1_q, ps2_dat_s2_q;
    logic             prev_clk_q, prev_clk_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [10:0]      frame_q, frame_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic tick, fall, frame_done, frame_ok;

    assign tick       = (div_q == DIV_MAX);
    assign fall       = tick && prev_clk_q && !ps2_clk_s2_q;
    assign frame_done = tick && (bit_cnt_q == 4'd11);
    // start bit low, stop bit high, odd parity across data and parity bit
    assign frame_ok   = !frame_q[0] && frame_q[10] && (^frame_q[9:1]);

    // Next-state for divider, edge sampler, shift register and timeout.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        div_d      = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        prev_clk_d = tick ? ps2_clk_s2_q : prev_clk_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        to_cnt_d   = to_cnt_q;

        if (frame_done) begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
        end else if (fall) begin
            frame_d   = {ps2_dat_s2_q, frame_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            to_cnt_d  = '0;
        end else if (tick && (bit_cnt_q != 4'd0)) begin
            if (to_cnt_q == TO_MAX) begin
                // stalled mid-frame: silently drop what was collected
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                frame_d   = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Front-end registers; synchronisers preset to the idle-high bus level.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: clocked state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (!RST_N) begin
            ps2_clk_s1_q <= 1'b1;
            ps2_clk_s2_q <= 1'b1;
            ps2_dat_s1_q <= 1'b1;
            ps2_dat_s2_q <= 1'b1;
            prev_clk_q   <= 1'b1;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            to_cnt_q     <= '0;
        end else begin
            ps2_clk_s1_q <= PS2_CLK;
            ps2_clk_s2_q <= ps2_clk_s1_q;
            ps2_dat_s1_q <= PS2_DATA;
            ps2_dat_s2_q <= ps2_dat_s1_q;
            prev_clk_q   <= prev_clk_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_q      <= frame_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder: registered push request and frame-error pulse
    // ------------------------------------------------------------------
    dec_state_t state_q;
    logic       push_q;
    evt_t       push_evt_q;
    logic       frame_err_q;
    logic [7:0] rx_byte;

    assign rx_byte = frame_q[8:1];

    // Decoder FSM acts on the tick where a complete frame is checked.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            push_q      <= 1'b0;
            push_evt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            if (frame_done) begin
                if (!frame_ok) begin
                    frame_err_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rx_byte == 8'hE0)      state_q <= ST_EXT;
                            else if (rx_byte == 8'hF0) state_q <= ST_BRK;
                        end
                        ST_EXT: begin
                            if (rx_byte == 8'hF0)      state_q <= ST_EXT_BRK;
                            else if (rx_byte == 8'hE0) state_q <= ST_EXT;
                        end
                        ST_BRK: begin
                            if (rx_byte == 8'hE0)      state_q <= ST_EXT_BRK;
                        end
                        default: ;
                    endcase
                    if (!((state_q == ST_IDLE && (rx_byte == 8'hE0 || rx_byte == 8'hF0)) ||
                          (state_q == ST_EXT  && (rx_byte == 8'hE0 || rx_byte == 8'hF0)) ||
                          (state_q == ST_BRK  &&  rx_byte == 8'hE0))) begin
                        push_q          <= 1'b1;
                        push_evt_q.code <= rx_byte;
                        push_evt_q.brk  <= (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                        push_evt_q.ext  <= (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                        state_q         <= ST_IDLE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             full, pop, wr_en;
    evt_t             head;

    assign full  = (level_q == LVL_FULL);
    assign pop   = EVT_VALID && EVT_READY;
    assign wr_en = push_q && (!full || pop);
    assign head  = mem[rd_ptr_q];

    // Pointer, occupancy and overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q + LVL_W'(wr_en) - LVL_W'(pop);
        overflow_d = push_q && full && !pop;
    end

    // FIFO control registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array written on accepted pushes.
    always_ff @(posedge CLK) begin
        // NOTE: the array carries no reset; entries are only visible once
        // written, and the outputs below are masked while the FIFO is empty.
        if (wr_en) mem[wr_ptr_q] <= push_evt_q;
    end

    assign EVT_VALID  = (level_q != '0);
    assign EVT_CODE   = EVT_VALID ? head.code : 8'h00;
    assign EVT_BREAK  = EVT_VALID && head.brk;
    assign EVT_EXT    = EVT_VALID && head.ext;
    assign FRAME_ERR  = frame_err_q;
    assign OVERFLOW   = overflow_q;
    assign FIFO_LEVEL = level_q;

endmodule
